// File: rtl/gnn_pkg.sv
// Shared GNN definitions: feature geometry and the loader state encoding,
// used by both the feature loader and the aggregation stage.
package gnn_pkg;

  localparam int DEF_FEAT_SIZE = 5;
  localparam int NUM_NODES     = 4;
  localparam int NUM_FEAT      = 4;
  localparam int NUM_WORDS     = NUM_NODES * NUM_FEAT;
  localparam int IDX_W         = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_EMIT = 2'd2
  } load_state_e;

  // Node-major slot position of feature `feat` of node `node`.
  function automatic int word_idx(input int node, input int feat);
    return node * NUM_FEAT + feat;
  endfunction

endpackage

// File: rtl/feature_loader_if.sv
// Input stream of the feature loader: valid/ready handshake plus data word.
// With FEATURE_LOADER_SOF_EN defined it also carries a start-of-frame flag.
interface feature_loader_if #(
  parameter int FEAT_SIZE = gnn_pkg::DEF_FEAT_SIZE
);

  logic                        in_valid;
  logic signed [FEAT_SIZE-1:0] in_data;
  logic                        in_ready;
`ifdef FEATURE_LOADER_SOF_EN
  logic                        in_sof;

  modport master (output in_valid, output in_data, output in_sof, input in_ready);
  modport slave  (input in_valid, input in_data, input in_sof, output in_ready);
`else
  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
`endif

endinterface

// File: rtl/feat_slot_rf.sv
// Shadow store for words 0..14 of the frame being filled; word 15 never
// lands here because it is loaded straight into the output registers.
module feat_slot_rf
  import gnn_pkg::*;
#(
  parameter int FEAT_SIZE = DEF_FEAT_SIZE
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [IDX_W-1:0]     waddr_i,
  input  logic [FEAT_SIZE-1:0] wdata_i,
  output logic [FEAT_SIZE-1:0] slots_o [NUM_WORDS-1]
);

  logic [FEAT_SIZE-1:0] slot_q [NUM_WORDS-1];

  // NOTE: the store has no reset; a frame reaches the outputs only after
  // every slot has been rewritten, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (we_i && (waddr_i != IDX_W'(NUM_WORDS - 1))) begin
      slot_q[waddr_i] <= wdata_i;
    end
  end

  assign slots_o = slot_q;

endmodule

// File: rtl/feature_loader.sv
// Collects 16 feature words into a 4-node x 4-feature frame and presents it
// to the aggregation stage with a one-cycle strobe. Optional FEATURE_LOADER_SOF_EN.
module feature_loader
  import gnn_pkg::*;
#(
  parameter int FEAT_SIZE = DEF_FEAT_SIZE,
  parameter int CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  feature_loader_if.slave             in_if,
  output logic                        out_ready_load,
  output logic signed [FEAT_SIZE-1:0] x0_n0, x1_n0, x2_n0, x3_n0,
  output logic signed [FEAT_SIZE-1:0] x0_n1, x1_n1, x2_n1, x3_n1,
  output logic signed [FEAT_SIZE-1:0] x0_n2, x1_n2, x2_n2, x3_n2,
  output logic signed [FEAT_SIZE-1:0] x0_n3, x1_n3, x2_n3, x3_n3,
  output logic [CNT_W-1:0]            frame_cnt
`ifdef FEATURE_LOADER_SOF_EN
  ,
  output logic [CNT_W-1:0]            drop_cnt
`endif
);

  load_state_e          state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d, wr_idx;
  logic                 hs, last_word;
  logic [FEAT_SIZE-1:0] slots [NUM_WORDS-1];
  logic [FEAT_SIZE-1:0] x_q [NUM_WORDS];
  logic [FEAT_SIZE-1:0] x_d [NUM_WORDS];
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;

  // Reset wins over any handshake because ready drops with it.
  assign in_if.in_ready = ~rst;
  assign hs             = in_if.in_valid & in_if.in_ready;

`ifdef FEATURE_LOADER_SOF_EN
  logic             sof_hs;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // A start-of-frame word restarts the frame at slot 0; a partial frame is dropped.
  assign sof_hs     = hs & in_if.in_sof;
  assign wr_idx     = sof_hs ? '0 : idx_q;
  assign drop_cnt_d = (sof_hs && (idx_q != '0)) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign wr_idx = idx_q;
`endif

  assign last_word = hs && (wr_idx == IDX_W'(NUM_WORDS - 1));
  assign idx_d     = hs ? wr_idx + IDX_W'(1) : idx_q;

  feat_slot_rf #(
    .FEAT_SIZE (FEAT_SIZE)
  ) u_slot_rf (
    .clk     (clk),
    .we_i    (hs),
    .waddr_i (wr_idx),
    .wdata_i (in_if.in_data),
    .slots_o (slots)
  );

  // NOTE: every combinational output is given its default first, so no
  // branch can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hs)        state_d = ST_FILL;
      ST_FILL: if (last_word) state_d = ST_EMIT;
      ST_EMIT:                state_d = hs ? ST_FILL : ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    x_d         = x_q;
    frame_cnt_d = frame_cnt_q;
    if (last_word) begin
      for (int k = 0; k < NUM_WORDS - 1; k++) x_d[k] = slots[k];
      x_d[NUM_WORDS-1] = in_if.in_data;
      frame_cnt_d      = frame_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: registers use non-blocking assignments so every one of them
  // updates from the values present before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      x_q         <= '{default: '0};
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_ready_load = (state_q == ST_EMIT);
  assign frame_cnt      = frame_cnt_q;

  assign x0_n0 = x_q[word_idx(0, 0)];
  assign x1_n0 = x_q[word_idx(0, 1)];
  assign x2_n0 = x_q[word_idx(0, 2)];
  assign x3_n0 = x_q[word_idx(0, 3)];
  assign x0_n1 = x_q[word_idx(1, 0)];
  assign x1_n1 = x_q[word_idx(1, 1)];
  assign x2_n1 = x_q[word_idx(1, 2)];
  assign x3_n1 = x_q[word_idx(1, 3)];
  assign x0_n2 = x_q[word_idx(2, 0)];
  assign x1_n2 = x_q[word_idx(2, 1)];
  assign x2_n2 = x_q[word_idx(2, 2)];
  assign x3_n2 = x_q[word_idx(2, 3)];
  assign x0_n3 = x_q[word_idx(3, 0)];
  assign x1_n3 = x_q[word_idx(3, 1)];
  assign x2_n3 = x_q[word_idx(3, 2)];
  assign x3_n3 = x_q[word_idx(3, 3)];

endmodule

// File: tb/tb_feature_loader.sv
// Scoreboard bench for feature_loader: the driver queues each expected frame,
// a negedge monitor checks strobes, frame contents and output stability.
module tb_feature_loader;
  import gnn_pkg::*;

  localparam int FS = 5;
  localparam int CW = 8;
  localparam int VW = NUM_WORDS * FS;

  typedef struct packed {
    logic [VW-1:0] w;
    logic [CW-1:0] fc;
    int            cyc;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  feature_loader_if #(.FEAT_SIZE(FS)) bus ();

  logic                 out_ready_load;
  logic signed [FS-1:0] x0_n0, x1_n0, x2_n0, x3_n0, x0_n1, x1_n1, x2_n1, x3_n1;
  logic signed [FS-1:0] x0_n2, x1_n2, x2_n2, x3_n2, x0_n3, x1_n3, x2_n3, x3_n3;
  logic [CW-1:0]        frame_cnt;
`ifdef FEATURE_LOADER_SOF_EN
  logic [CW-1:0]        drop_cnt;
`endif

  feature_loader #(.FEAT_SIZE(FS), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_if          (bus),
    .out_ready_load (out_ready_load),
    .x0_n0 (x0_n0), .x1_n0 (x1_n0), .x2_n0 (x2_n0), .x3_n0 (x3_n0),
    .x0_n1 (x0_n1), .x1_n1 (x1_n1), .x2_n1 (x2_n1), .x3_n1 (x3_n1),
    .x0_n2 (x0_n2), .x1_n2 (x1_n2), .x2_n2 (x2_n2), .x3_n2 (x3_n2),
    .x0_n3 (x0_n3), .x1_n3 (x1_n3), .x2_n3 (x2_n3), .x3_n3 (x3_n3),
    .frame_cnt      (frame_cnt)
`ifdef FEATURE_LOADER_SOF_EN
    ,
    .drop_cnt       (drop_cnt)
`endif
  );

  // Word k (node k/4, feature k%4) sits at bits [k*FS +: FS].
  logic [VW-1:0] act_v;
  assign act_v = {x3_n3, x2_n3, x1_n3, x0_n3, x3_n2, x2_n2, x1_n2, x0_n2,
                  x3_n1, x2_n1, x1_n1, x0_n1, x3_n0, x2_n0, x1_n0, x0_n0};

  int            n_total = 0;
  int            n_bad   = 0;
  int            cyc     = 0;
  bit            hold_en = 1'b0;
  frame_t        exp_q[$];
  int            strobe_log[$];
  logic [VW-1:0] snap_w  = '0;
  logic [CW-1:0] snap_fc = '0;
  logic [VW-1:0] cur_w   = '0;
  logic [CW-1:0] exp_frames = '0;
  int            word_pos = 0;
  frame_t        mon_e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the head of the scoreboard; between
  // strobes the outputs must hold the last emitted frame.
  always @(negedge clk) begin
    if (out_ready_load === 1'b1) begin
      strobe_log.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_strobe: got strobe expected none (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_cycle", cyc, mon_e.cyc);
        check("frame_words", act_v, mon_e.w);
        check("frame_cnt_at_strobe", frame_cnt, mon_e.fc);
        snap_w  = mon_e.w;
        snap_fc = mon_e.fc;
      end
    end else if (hold_en) begin
      check("hold_words", act_v, snap_w);
      check("hold_frame_cnt", frame_cnt, snap_fc);
    end
  end

  // Drive one word; the strobe is due on the cycle after the accepting edge.
  task automatic send(input logic [FS-1:0] d, input bit sof);
    frame_t f;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
`ifdef FEATURE_LOADER_SOF_EN
    bus.in_sof   = sof;
    if (sof) word_pos = 0;
`else
    if (sof) word_pos = 0;
`endif
    cur_w[word_pos*FS +: FS] = d;
    if (word_pos == NUM_WORDS - 1) begin
      exp_frames = exp_frames + 8'd1;
      f.w   = cur_w;
      f.fc  = exp_frames;
      f.cyc = cyc + 1;
      exp_q.push_back(f);
      word_pos = 0;
    end else begin
      word_pos++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
`ifdef FEATURE_LOADER_SOF_EN
      bus.in_sof   = 1'b0;
`endif
    end
  endtask

  task automatic drain();
    idle(1);
    for (int b = 0; b < 40 && exp_q.size() != 0; b++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      n_bad++;
      $display("FAIL strobe_timeout: got %0d frames pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Pulse reset for one edge, optionally with a word offered during it.
  task automatic do_reset(input bit with_word);
    hold_en = 1'b0;
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = with_word;
    bus.in_data  = 5'h1F;
    @(negedge clk);
    check("rst_strobe", out_ready_load, 1'b0);
    check("rst_words", act_v, '0);
    check("rst_frame_cnt", frame_cnt, '0);
    check("rst_in_ready", bus.in_ready, 1'b0);
`ifdef FEATURE_LOADER_SOF_EN
    check("rst_drop_cnt", drop_cnt, '0);
`endif
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    word_pos   = 0;
    exp_frames = '0;
    snap_w     = '0;
    snap_fc    = '0;
    @(negedge clk);
    check("in_ready_after_rst", bus.in_ready, 1'b1);
    hold_en = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
`ifdef FEATURE_LOADER_SOF_EN
    bus.in_sof   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    do_reset(1'b0);

    // Words 1..16 back to back: 16 wraps to -16 in five bits.
    for (int k = 0; k < 16; k++) send(5'(k + 1), 1'b0);
    drain();
    check("x0_n0", $unsigned(x0_n0), 5'd1);
    check("x3_n0", $unsigned(x3_n0), 5'd4);
    check("x0_n1", $unsigned(x0_n1), 5'd5);
    check("x3_n3", $unsigned(x3_n3), 5'b10000);
    check("frame_cnt_one", frame_cnt, 8'd1);

    // Two continuous frames: the second one's word 0 lands in the strobe cycle.
    strobe_log.delete();
    for (int k = 0; k < 16; k++) send(5'(3 * k + 2), 1'b0);
    for (int k = 0; k < 16; k++) send(5'(31 - 2 * k), 1'b0);
    drain();
    check("b2b_strobe_count", strobe_log.size(), 2);
    if (strobe_log.size() == 2) check("b2b_strobe_gap", strobe_log[1] - strobe_log[0], 16);
    check("frame_cnt_three", frame_cnt, 8'd3);

    // Half a frame, a 5-cycle gap, then the rest: one strobe only.
    strobe_log.delete();
    for (int k = 0; k < 8; k++) send(5'(5 * k), 1'b0);
    idle(5);
    for (int k = 8; k < 16; k++) send(5'(5 * k), 1'b0);
    drain();
    check("gap_strobe_count", strobe_log.size(), 1);

    // Reset after word 10 discards the partial frame.
    strobe_log.delete();
    for (int k = 0; k < 10; k++) send(5'(k + 7), 1'b0);
    do_reset(1'b0);
    for (int k = 0; k < 16; k++) send(5'(20 - k), 1'b0);
    drain();
    check("abort_strobe_count", strobe_log.size(), 1);
    check("abort_x0_n0", $unsigned(x0_n0), 5'd20);
    check("abort_x3_n3", $unsigned(x3_n3), 5'd5);
    check("abort_frame_cnt", frame_cnt, 8'd1);

    // Reset in the cycle that would accept word 15: no strobe afterwards.
    strobe_log.delete();
    for (int k = 0; k < 15; k++) send(5'(k + 3), 1'b0);
    do_reset(1'b1);
    idle(20);
    check("rst_load_strobe_count", strobe_log.size(), 0);

`ifdef FEATURE_LOADER_SOF_EN
    // Start-of-frame on word 6 drops the partial frame and restarts at slot 0.
    for (int k = 0; k < 6; k++) send(5'(k + 1), 1'b0);
    send(5'd9, 1'b1);
    for (int k = 0; k < 15; k++) send(5'(k + 20), 1'b0);
    drain();
    check("sof_drop_cnt", drop_cnt, 8'd1);
    check("sof_x0_n0", $unsigned(x0_n0), 5'd9);
    check("sof_x1_n0", $unsigned(x1_n0), 5'd20);
    check("sof_x3_n3", $unsigned(x3_n3), 5'd2);
    // Start-of-frame on word 0 is an ordinary frame start.
    send(5'd11, 1'b1);
    for (int k = 1; k < 16; k++) send(5'(k), 1'b0);
    drain();
    check("sof_word0_drop_cnt", drop_cnt, 8'd1);
    check("sof_word0_x0_n0", $unsigned(x0_n0), 5'd11);
`endif

    // 256 frames wrap the 8-bit frame counter back to 0.
    do_reset(1'b0);
    strobe_log.delete();
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < 16; k++) send(5'(f + k), 1'b0);
    end
    drain();
    check("wrap_strobe_count", strobe_log.size(), 256);
    check("wrap_frame_cnt", frame_cnt, 8'd0);

    idle(2);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/feature_loader.md
FEATURE_LOADER -- requirements
Module: feature_loader

Interface
REQ-001 SHALL have parameter FEAT_SIZE, default 5: signed width of one node-feature word; must equal the downstream AGGR_IN_SIZE.
REQ-002 SHALL have parameter CNT_W, default 8: width of the frame and drop counters.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: the word on in_data is valid this cycle.
REQ-006 SHALL have port in_data, input, FEAT_SIZE bits: signed feature word.
REQ-007 SHALL have port in_ready, output, 1 bit: loader accepts in_data this cycle.
REQ-008 SHALL have port out_ready_load, output, 1 bit: one-cycle frame strobe that drives the aggregation stage's in_ready_aggr.
REQ-009 SHALL have ports xF_nN (F, N in 0..3), output, FEAT_SIZE bits each, signed: 16 registered feature outputs that drive the aggregation inputs of the same name.
REQ-010 SHALL have port frame_cnt, output, CNT_W bits: count of emitted frames.

Function
REQ-011 SHALL complete a handshake on every cycle in which in_valid and in_ready are both 1.
REQ-012 SHALL write accepted word k (k = 0..15) to slot node N = k/4, feature F = k%4 (node-major order), using a 4-bit write index.
REQ-013 SHALL keep in_ready at 1 in every state except during reset.
REQ-014 SHALL use states IDLE (index 0, no frame in progress), FILL (0 < index < 16) and EMIT (strobe cycle).
REQ-015 SHALL make these transitions: IDLE to FILL on the first handshake; FILL to EMIT on the handshake that fills slot 15; EMIT to FILL if a handshake occurs in EMIT, otherwise EMIT to IDLE.
REQ-016 SHALL, on the edge that accepts word 15, load all 16 outputs together from the 15 shadow slots plus in_data.
REQ-017 SHALL hold out_ready_load at 1 for exactly the following cycle (EMIT); latency is 1 cycle from the last handshake.
REQ-018 SHALL hold the xF_nN outputs stable between frame loads; a partially filled frame SHALL never appear on them.
REQ-019 SHALL accept a handshake in EMIT as word 0 of the next frame, giving back-to-back frames with one strobe every 16 cycles.
REQ-020 SHALL wrap the write index from 15 to 0.
REQ-021 SHALL increment frame_cnt on each strobe, wrapping modulo 2^CNT_W.
REQ-022 SHALL store words without sign extension or arithmetic; width growth is the aggregation stage's job.

Reset
REQ-023 SHALL, while rst is 1, set the state to IDLE, the index to 0, out_ready_load to 0, all xF_nN to 0, frame_cnt to 0 and in_ready to 0.
REQ-024 SHALL treat rst as taking priority over any handshake in the same cycle.
REQ-025 SHALL discard any partial frame when reset is asserted mid-fill, with no strobe.
REQ-026 SHALL suppress a pending EMIT strobe when reset is asserted in the load cycle.

Configuration
REQ-027 SHALL, when macro FEATURE_LOADER_SOF_EN is defined, add input in_sof (1 bit) and output drop_cnt (CNT_W bits, reset 0).
REQ-028 SHALL, with FEATURE_LOADER_SOF_EN defined, write any handshaked word with in_sof=1 to slot 0 and set the index to 1.
REQ-029 SHALL, with FEATURE_LOADER_SOF_EN defined, increment drop_cnt (wrapping) when such an in_sof word arrives with index not 0, and discard that partial frame.
REQ-030 SHALL treat in_sof=1 on word 0 as normal, with no drop.
REQ-031 SHALL, when FEATURE_LOADER_SOF_EN is not defined, omit both ports and perform no resynchronisation.

Structure
REQ-032 SHALL take FEAT_SIZE default, NUM_NODES=4, NUM_FEAT=4 and the state-encoding enum from the shared package gnn_pkg, which the aggregation stage also uses.
REQ-033 SHALL implement the 15-slot shadow store with write decode as sub-module feat_slot_rf; the FSM, counters and output registers stay in feature_loader.

Verification
REQ-034 SHALL verify: 16 words 1..16 back-to-back -> strobe 1 cycle after the last handshake; x0_n0=1, x3_n0=4, x0_n1=5, x3_n3=-16 (5-bit wrap of 16); frame_cnt=1.
REQ-035 SHALL verify: two frames streamed continuously -> strobes exactly 16 cycles apart; outputs unchanged between strobes.
REQ-036 SHALL verify: 8 words, in_valid low for 5 cycles, then 8 words -> single strobe; no output change before it.
REQ-037 SHALL verify: rst pulsed after word 10, then 16 fresh words -> no strobe for the aborted frame; outputs are the fresh frame.
REQ-038 SHALL verify (FEATURE_LOADER_SOF_EN defined): in_sof on word 6 then 15 more words -> drop_cnt=1; that word appears at x0_n0.
REQ-039 SHALL verify: 256 frames -> frame_cnt wraps to 0.
